// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles WIDTH qualified bits into a word,
// presents it on a registered output with valid/ready handshake and sticky overrun.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_p0;
    logic [WIDTH-1:0] sh_next;
    logic             word_done;
    logic             out_free;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                   input logic             bit_in);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], bit_in};
        else
            return {bit_in, cur[WIDTH-1:1]};
    endfunction

    assign sh_next   = shift_in(sh_p0, d);
    assign word_done = d_valid && (bit_cnt == LAST_BIT);
    // The holding register may take a new word if empty or being drained this edge.
    assign out_free  = !o_valid || o_ready;

    // Stage p0: partial-word assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_p0   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            sh_p0   <= '0;
            bit_cnt <= '0;
        end else if (d_valid) begin
            sh_p0   <= sh_next;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
    end

    // Stage p1: output holding register and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o       <= '0;
            o_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            o_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (word_done) begin
            if (out_free) begin
                o       <= sh_next;
                o_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: three instances (4-bit MSB-first, 4-bit
// LSB-first, 8-bit MSB-first) checked every cycle against a bit-list model.
module tb_sipo_deserializer;

    logic clk, rst, clear, d, d_valid, o_ready;

    logic [3:0] o_a, o_b;
    logic [7:0] o_c;
    logic       vld_a, vld_b, vld_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic [1:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .d(d), .d_valid(d_valid),
        .o(o_a), .o_valid(vld_a), .o_ready(o_ready), .bit_cnt(cnt_a), .overrun(ovr_a));
    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .d(d), .d_valid(d_valid),
        .o(o_b), .o_valid(vld_b), .o_ready(o_ready), .bit_cnt(cnt_b), .overrun(ovr_b));
    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .clear(clear), .d(d), .d_valid(d_valid),
        .o(o_c), .o_valid(vld_c), .o_ready(o_ready), .bit_cnt(cnt_c), .overrun(ovr_c));

    int checks = 0;
    int errors = 0;

    // Model state per instance: received bits of the partial word, then packed.
    int         mw   [3] = '{4, 4, 8};
    bit         mmsb [3] = '{1'b1, 1'b0, 1'b1};
    int         mcnt [3] = '{0, 0, 0};
    logic [7:0] mo   [3] = '{8'h0, 8'h0, 8'h0};
    bit         mv   [3] = '{1'b0, 1'b0, 1'b0};
    bit         movr [3] = '{1'b0, 1'b0, 1'b0};
    bit         mbits[3][8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] word;
        bit         done;
        word = 8'h0;
        done = 1'b0;
        if (rst) begin
            mcnt[k] = 0; mo[k] = 8'h0; mv[k] = 1'b0; movr[k] = 1'b0;
        end else if (clear) begin
            mcnt[k] = 0; mv[k] = 1'b0; movr[k] = 1'b0;
        end else begin
            if (d_valid) begin
                mbits[k][mcnt[k]] = d;
                mcnt[k]++;
                if (mcnt[k] == mw[k]) begin
                    for (int i = 0; i < mw[k]; i++) begin
                        if (mmsb[k]) word[mw[k]-1-i] = mbits[k][i];
                        else         word[i]         = mbits[k][i];
                    end
                    mcnt[k] = 0;
                    done    = 1'b1;
                end
            end
            if (done) begin
                if (!mv[k] || o_ready) begin
                    mo[k] = word;
                    mv[k] = 1'b1;
                end else begin
                    movr[k] = 1'b1;
                end
            end else if (mv[k] && o_ready) begin
                mv[k] = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("a.o",       32'(o_a),   32'(mo[0]));
                chk("a.o_valid", 32'(vld_a), 32'(mv[0]));
                chk("a.overrun", 32'(ovr_a), 32'(movr[0]));
                chk("a.bit_cnt", 32'(cnt_a), 32'(mcnt[0]));
                chk("b.o",       32'(o_b),   32'(mo[1]));
                chk("b.o_valid", 32'(vld_b), 32'(mv[1]));
                chk("b.overrun", 32'(ovr_b), 32'(movr[1]));
                chk("b.bit_cnt", 32'(cnt_b), 32'(mcnt[1]));
                chk("c.o",       32'(o_c),   32'(mo[2]));
                chk("c.o_valid", 32'(vld_c), 32'(mv[2]));
                chk("c.overrun", 32'(ovr_c), 32'(movr[2]));
                chk("c.bit_cnt", 32'(cnt_c), 32'(mcnt[2]));
            end
        end
    end

    // Drive one cycle of inputs, return just after the capturing edge.
    task automatic cyc(input logic dv, input logic dd, input logic cl);
        @(negedge clk);
        #1;
        d_valid = dv;
        d       = dd;
        clear   = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word4(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) cyc(1'b1, w[i], 1'b0);
    endtask

    initial begin
        logic [7:0] w8;
        logic [3:0] wg;
        rst = 1'b1; clear = 1'b0; d = 1'b0; d_valid = 1'b0; o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset o",       32'(o_a),   32'h0);
        chk("reset o_valid", 32'(vld_a), 32'h0);
        chk("reset bit_cnt", 32'(cnt_a), 32'h0);
        chk("reset overrun", 32'(ovr_a), 32'h0);
        rst = 1'b0;

        // Basic word 1,0,1,1 in both bit orders
        cyc(1'b1, 1'b1, 1'b0); chk("seq cnt1", 32'(cnt_a), 32'd1);
        cyc(1'b1, 1'b0, 1'b0); chk("seq cnt2", 32'(cnt_a), 32'd2);
        cyc(1'b1, 1'b1, 1'b0); chk("seq cnt3", 32'(cnt_a), 32'd3);
        cyc(1'b1, 1'b1, 1'b0); chk("seq cnt0", 32'(cnt_a), 32'd0);
        chk("msb o 1011",  32'(o_a),   32'hB);
        chk("msb o_valid", 32'(vld_a), 32'h1);
        chk("lsb o 1101",  32'(o_b),   32'hD);
        cyc(1'b0, 1'b0, 1'b0);
        chk("consumed o_valid", 32'(vld_a), 32'h0);

        // 8-bit word 0xCA
        cyc(1'b0, 1'b0, 1'b1);
        w8 = 8'hCA;
        for (int i = 7; i >= 0; i--) cyc(1'b1, w8[i], 1'b0);
        chk("w8 o CA",      32'(o_c),   32'hCA);
        chk("w8 o_valid",   32'(vld_c), 32'h1);
        chk("w4 second A",  32'(o_a),   32'hA);

        // Gapped input 0,1,1,0
        cyc(1'b0, 1'b0, 1'b1);
        wg = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, wg[3-i], 1'b0);
            if (i == 3) begin
                chk("gap o 0110",  32'(o_a),   32'h6);
                chk("gap o_valid", 32'(vld_a), 32'h1);
            end else begin
                chk("gap early o_valid", 32'(vld_a), 32'h0);
            end
            repeat (3) begin
                cyc(1'b0, 1'b0, 1'b0);
                chk("gap cnt hold", 32'(cnt_a), 32'((i + 1) % 4));
            end
        end

        // Backpressure and overrun
        cyc(1'b0, 1'b0, 1'b1);
        o_ready = 1'b0;
        send_word4(4'hA);
        chk("bp first o",   32'(o_a),   32'hA);
        chk("bp first vld", 32'(vld_a), 32'h1);
        chk("bp first ovr", 32'(ovr_a), 32'h0);
        send_word4(4'h5);
        chk("bp held o",    32'(o_a),   32'hA);
        chk("bp held vld",  32'(vld_a), 32'h1);
        chk("bp overrun",   32'(ovr_a), 32'h1);
        o_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("bp drain vld",   32'(vld_a), 32'h0);
        chk("bp sticky ovr",  32'(ovr_a), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("bp sticky ovr2", 32'(ovr_a), 32'h1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("clear ovr",      32'(ovr_a), 32'h0);

        // Streaming back-to-back words
        send_word4(4'h3);
        chk("stream 3",     32'(o_a),   32'h3);
        chk("stream 3 vld", 32'(vld_a), 32'h1);
        send_word4(4'hC);
        chk("stream C",     32'(o_a),   32'hC);
        chk("stream C vld", 32'(vld_a), 32'h1);
        send_word4(4'h9);
        chk("stream 9",     32'(o_a),   32'h9);
        chk("stream 9 vld", 32'(vld_a), 32'h1);
        chk("stream ovr",   32'(ovr_a), 32'h0);

        // Async reset mid-word
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pre-rst cnt", 32'(cnt_a), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("async rst cnt", 32'(cnt_a), 32'h0);
        chk("async rst o",   32'(o_a),   32'h0);
        chk("async rst vld", 32'(vld_a), 32'h0);
        #1 rst = 1'b0;
        send_word4(4'hE);
        chk("post-rst o E",  32'(o_a),   32'hE);
        chk("post-rst vld",  32'(vld_a), 32'h1);

        // Clear with d_valid on the same edge after 3 bits
        o_ready = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("pre-clear cnt", 32'(cnt_a), 32'd3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clear cnt",  32'(cnt_a), 32'h0);
        chk("clear o",    32'(o_a),   32'hE);
        chk("clear vld",  32'(vld_a), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("after clear cnt", 32'(cnt_a), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
